// File: rtl/yuv_pkg.sv
`default_nettype none
// ============================================================================
//  Module : yuv_pkg
//  Brief  : Pixel layouts, FSM encodings and chroma helper for the 444->422 packer
//  Rev    : 1.0  initial release
// ============================================================================
package yuv_pkg;

    typedef struct packed {
        logic [7:0] pad;
        logic [7:0] y;
        logic [7:0] u;
        logic [7:0] v;
    } yuv444_px_t;

    typedef struct packed {
        logic [7:0] v;
        logic [7:0] y1;
        logic [7:0] u;
        logic [7:0] y0;
    } yuv422_pair_t;

    localparam logic [0:0] C_ST_EMPTY  = 1'b0;
    localparam logic [0:0] C_ST_HALF   = 1'b1;

    localparam logic [7:0] C_KEEP_HALF = 8'h0F;
    localparam logic [7:0] C_KEEP_FULL = 8'hFF;

    // The 9-bit sum keeps FF+FF+1 from wrapping before the halving.
    function automatic logic [7:0] chroma_avg(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b} + 9'd1;
        return sum[8:1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/yuv444_pair_to_422.sv
`default_nettype none
// ============================================================================
//  Module : yuv444_pair_to_422
//  Brief  : Combinational merge of two 444 pixels into one shared-chroma 422 pair
//  Rev    : 1.0  initial release
// ============================================================================
module yuv444_pair_to_422
    import yuv_pkg::*;
#(
    parameter int AVERAGE = 1
) (
    input  logic [63:0]  i_word,
    output yuv422_pair_t o_pair
);

    yuv444_px_t px0;
    yuv444_px_t px1;
    logic [7:0] w_u;
    logic [7:0] w_v;
    logic       w_unused_pad;

    assign px0          = i_word[31:0];
    assign px1          = i_word[63:32];
    assign w_unused_pad = ^{px0.pad, px1.pad};

    generate
        if (AVERAGE != 0) begin : g_avg
            assign w_u = chroma_avg(px0.u, px1.u);
            assign w_v = chroma_avg(px0.v, px1.v);
        end else begin : g_dec
            logic w_unused_odd;
            assign w_u          = px0.u;
            assign w_v          = px0.v;
            assign w_unused_odd = ^{px1.u, px1.v};
        end
    endgenerate

    assign o_pair = {w_v, px1.y, w_u, px0.y};

endmodule
`default_nettype wire

// File: rtl/yuv444to422_pack.sv
`default_nettype none
// ============================================================================
//  Module : yuv444to422_pack
//  Brief  : Packs two 2-pixel 444 beats into one 4-pixel 422 beat on a stream
//  Rev    : 1.0  initial release
// ============================================================================
module yuv444to422_pack
    import yuv_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1,
    parameter int DEST_WIDTH = 1,
    parameter int CHAIN_ID   = 0,
    parameter int AVERAGE    = 1
) (
    input  logic                    aclk,
    input  logic                    areset,

    input  logic                    src_t_valid,
    output logic                    src_t_ready,
    input  logic [DATA_WIDTH-1:0]   src_t_data,
    input  logic [DATA_WIDTH/8-1:0] src_t_keep,
    input  logic [DATA_WIDTH/8-1:0] src_t_strb,
    input  logic                    src_t_last,
    input  logic [USER_WIDTH-1:0]   src_t_user,
    input  logic [DEST_WIDTH-1:0]   src_t_dest,

    output logic                    dst_t_valid,
    input  logic                    dst_t_ready,
    output logic [DATA_WIDTH-1:0]   dst_t_data,
    output logic [DATA_WIDTH/8-1:0] dst_t_keep,
    output logic [DATA_WIDTH/8-1:0] dst_t_strb,
    output logic                    dst_t_last,
    output logic [USER_WIDTH-1:0]   dst_t_user,
    output logic [DEST_WIDTH-1:0]   dst_t_dest
);

    generate
        if (DATA_WIDTH != 64) begin : g_bad_width
            $error("yuv444to422_pack: only DATA_WIDTH=64 is supported");
        end
    endgenerate

    yuv422_pair_t            w_word;
    logic [0:0]              state_q, state_d;
    logic [31:0]             pack_q, pack_d;
    logic [USER_WIDTH-1:0]   user_q, user_d;
    logic                    match_q, match_d;
    logic                    dst_valid_q, dst_valid_d;
    logic [DATA_WIDTH-1:0]   dst_data_q, dst_data_d;
    logic [DATA_WIDTH/8-1:0] dst_keep_q, dst_keep_d;
    logic                    dst_last_q, dst_last_d;
    logic [USER_WIDTH-1:0]   dst_user_q, dst_user_d;

    logic                    w_accept;
    logic                    w_emit;
    logic                    w_load_half;
    logic                    w_src_match;
    logic [USER_WIDTH:0]     w_user_full;
    logic                    w_unused_user;

    yuv444_pair_to_422 #(
        .AVERAGE (AVERAGE)
    ) u_pair (
        .i_word  (src_t_data[63:0]),
        .o_pair  (w_word)
    );

    assign src_t_ready = !dst_valid_q || dst_t_ready;
    assign w_accept    = src_t_valid && src_t_ready;
    assign w_src_match = (src_t_dest == DEST_WIDTH'(CHAIN_ID));

    // Sideband always comes from the first beat of the pair: latched in HALF, live in EMPTY.
    assign w_user_full   = (state_q == C_ST_HALF) ? {user_q, match_q} : {src_t_user, w_src_match};
    assign w_unused_user = ^w_user_full;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= C_ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (w_accept) begin
            if (state_q == C_ST_EMPTY && !src_t_last) begin
                state_d = C_ST_HALF;
            end else begin
                state_d = C_ST_EMPTY;
            end
        end
    end

    always_comb begin
        w_emit      = 1'b0;
        w_load_half = 1'b0;
        if (w_accept) begin
            if (state_q == C_ST_HALF || src_t_last) begin
                w_emit = 1'b1;
            end else begin
                w_load_half = 1'b1;
            end
        end
    end

    always_comb begin
        pack_d      = pack_q;
        user_d      = user_q;
        match_d     = match_q;
        dst_valid_d = dst_valid_q;
        dst_data_d  = dst_data_q;
        dst_keep_d  = dst_keep_q;
        dst_last_d  = dst_last_q;
        dst_user_d  = dst_user_q;

        if (w_load_half) begin
            pack_d  = w_word;
            user_d  = src_t_user;
            match_d = w_src_match;
        end

        if (w_emit) begin
            dst_valid_d = 1'b1;
            dst_last_d  = src_t_last;
            dst_user_d  = w_user_full[USER_WIDTH-1:0];
            if (state_q == C_ST_HALF) begin
                dst_data_d = {w_word, pack_q};
                dst_keep_d = C_KEEP_FULL;
            end else begin
                dst_data_d = {32'h0, w_word};
                dst_keep_d = C_KEEP_HALF;
            end
        end else if (dst_t_ready) begin
            dst_valid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            pack_q      <= '0;
            user_q      <= '0;
            match_q     <= 1'b0;
            dst_valid_q <= 1'b0;
            dst_data_q  <= '0;
            dst_keep_q  <= '0;
            dst_last_q  <= 1'b0;
            dst_user_q  <= '0;
        end else begin
            pack_q      <= pack_d;
            user_q      <= user_d;
            match_q     <= match_d;
            dst_valid_q <= dst_valid_d;
            dst_data_q  <= dst_data_d;
            dst_keep_q  <= dst_keep_d;
            dst_last_q  <= dst_last_d;
            dst_user_q  <= dst_user_d;
        end
    end

    assign dst_t_valid = dst_valid_q;
    assign dst_t_data  = dst_data_q;
    assign dst_t_keep  = dst_keep_q;
    assign dst_t_strb  = dst_keep_q;
    assign dst_t_last  = dst_last_q;
    assign dst_t_user  = dst_user_q;
    assign dst_t_dest  = '0;

`ifndef SYNTHESIS
    always_ff @(posedge aclk) begin
        assert (areset || !src_t_valid || (&src_t_keep && &src_t_strb))
            else $error("Null byte not supported");
    end

    a_dst_stable : assert property (@(posedge aclk)
        (!areset && dst_t_valid && !dst_t_ready) |=>
        (areset || $stable({dst_t_data, dst_t_keep, dst_t_strb, dst_t_last, dst_t_user})))
        else $error("dst payload changed while stalled");
`endif

endmodule
`default_nettype wire

// File: tb/tb_yuv444to422_pack.sv
`default_nettype none
// ============================================================================
//  Module : tb_yuv444to422_pack
//  Brief  : Random and directed stimulus against a queue-based pixel packing model
//  Rev    : 1.0  initial release
// ============================================================================
module tb_yuv444to422_pack;

    localparam int C_CHAIN = 1;

    logic        aclk = 1'b0;
    logic        areset;
    logic        src_t_valid, src_t_ready, src_t_last;
    logic [63:0] src_t_data;
    logic [7:0]  src_t_keep, src_t_strb;
    logic [0:0]  src_t_user, src_t_dest;
    logic        dst_t_valid, dst_t_ready, dst_t_last;
    logic [63:0] dst_t_data;
    logic [7:0]  dst_t_keep, dst_t_strb;
    logic [0:0]  dst_t_user, dst_t_dest;
    logic        dec_valid, dec_src_ready, dec_last;
    logic [63:0] dec_data;
    logic [7:0]  dec_keep, dec_strb;
    logic [0:0]  dec_user, dec_dest;

    int n_checks = 0;
    int n_errors = 0;
    int rdy_mode = 0;

    typedef struct {
        logic [63:0] d_avg;
        logic [63:0] d_dec;
        logic [7:0]  keep;
        logic        last;
        logic        user;
    } exp_t;

    exp_t        exp_q[$];
    bit          have_pend = 1'b0;
    logic [31:0] pend_avg, pend_dec;
    logic        pend_user;

    always #5 aclk = ~aclk;

    yuv444to422_pack #(.DATA_WIDTH(64), .USER_WIDTH(1), .DEST_WIDTH(1),
                       .CHAIN_ID(C_CHAIN), .AVERAGE(1)) u_dut (
        .aclk(aclk), .areset(areset),
        .src_t_valid(src_t_valid), .src_t_ready(src_t_ready), .src_t_data(src_t_data),
        .src_t_keep(src_t_keep), .src_t_strb(src_t_strb), .src_t_last(src_t_last),
        .src_t_user(src_t_user), .src_t_dest(src_t_dest),
        .dst_t_valid(dst_t_valid), .dst_t_ready(dst_t_ready), .dst_t_data(dst_t_data),
        .dst_t_keep(dst_t_keep), .dst_t_strb(dst_t_strb), .dst_t_last(dst_t_last),
        .dst_t_user(dst_t_user), .dst_t_dest(dst_t_dest)
    );

    yuv444to422_pack #(.DATA_WIDTH(64), .USER_WIDTH(1), .DEST_WIDTH(1),
                       .CHAIN_ID(C_CHAIN), .AVERAGE(0)) u_dut_dec (
        .aclk(aclk), .areset(areset),
        .src_t_valid(src_t_valid), .src_t_ready(dec_src_ready), .src_t_data(src_t_data),
        .src_t_keep(src_t_keep), .src_t_strb(src_t_strb), .src_t_last(src_t_last),
        .src_t_user(src_t_user), .src_t_dest(src_t_dest),
        .dst_t_valid(dec_valid), .dst_t_ready(dst_t_ready), .dst_t_data(dec_data),
        .dst_t_keep(dec_keep), .dst_t_strb(dec_strb), .dst_t_last(dec_last),
        .dst_t_user(dec_user), .dst_t_dest(dec_dest)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference pixel pair: each 444 pixel is {pad, Y, U, V} from MSB to LSB.
    function automatic logic [31:0] model_word(input logic [63:0] d, input bit avg);
        int y0, u0, v0, y1, u1, v1, u, v;
        y0 = int'(d[23:16]); u0 = int'(d[15:8]);  v0 = int'(d[7:0]);
        y1 = int'(d[55:48]); u1 = int'(d[47:40]); v1 = int'(d[39:32]);
        u  = avg ? (u0 + u1 + 1) / 2 : u0;
        v  = avg ? (v0 + v1 + 1) / 2 : v0;
        return {v[7:0], y1[7:0], u[7:0], y0[7:0]};
    endfunction

    initial begin
        exp_t        e;
        logic [31:0] wa, wd;
        logic        m;
        forever begin
            @(negedge aclk);
            if (areset) begin
                exp_q.delete();
                have_pend = 1'b0;
            end else begin
                if (dst_t_valid && dst_t_ready) begin
                    check_eq("beat_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check_eq("data_avg", dst_t_data, e.d_avg);
                        check_eq("data_dec", dec_data, e.d_dec);
                        check_eq("keep", dst_t_keep, 64'(e.keep));
                        check_eq("strb", dst_t_strb, 64'(e.keep));
                        check_eq("last", dst_t_last, 64'(e.last));
                        check_eq("user", dst_t_user, 64'(e.user));
                        check_eq("dest", dst_t_dest, 64'd0);
                        check_eq("dec_side", {dec_valid, dec_keep, dec_strb, dec_last, dec_user, dec_dest},
                                 {1'b1, e.keep, e.keep, e.last, e.user, 1'b0});
                    end
                end
                check_eq("dec_src_ready", dec_src_ready, src_t_ready);
                if (src_t_valid && src_t_ready) begin
                    wa = model_word(src_t_data, 1'b1);
                    wd = model_word(src_t_data, 1'b0);
                    m  = (src_t_dest == 1'(C_CHAIN));
                    if (have_pend) begin
                        exp_q.push_back('{{wa, pend_avg}, {wd, pend_dec}, 8'hFF, src_t_last, pend_user});
                        have_pend = 1'b0;
                    end else if (!src_t_last) begin
                        have_pend = 1'b1;
                        pend_avg  = wa;
                        pend_dec  = wd;
                        pend_user = m;
                    end else begin
                        exp_q.push_back('{{32'h0, wa}, {32'h0, wd}, 8'h0F, 1'b1, m});
                    end
                end
            end
        end
    end

    initial begin
        dst_t_ready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            case (rdy_mode)
                0:       dst_t_ready = 1'b1;
                1:       dst_t_ready = 1'($urandom_range(0, 1));
                default: dst_t_ready = 1'b0;
            endcase
        end
    end

    task automatic send(input logic [63:0] d, input logic l, input logic u, input logic dd);
        int t;
        src_t_data  = d;
        src_t_last  = l;
        src_t_user  = u;
        src_t_dest  = dd;
        src_t_valid = 1'b1;
        t = 0;
        @(negedge aclk);
        while (!src_t_ready && t < 200) begin
            @(negedge aclk);
            t++;
        end
        check_eq("src_accept", src_t_ready, 1'b1);
        @(posedge aclk);
        #1;
        src_t_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        rdy_mode    = 0;
        dst_t_ready = 1'b1;
        t = 0;
        while ((exp_q.size() != 0 || dst_t_valid) && t < 100) begin
            @(negedge aclk);
            t++;
        end
        check_eq("drain_empty", exp_q.size(), 0);
        @(posedge aclk);
        #1;
    endtask

    task automatic set_ready(input int mode);
        rdy_mode    = mode;
        dst_t_ready = (mode == 0);
    endtask

    initial begin
        logic [63:0] q;
        areset      = 1'b1;
        src_t_valid = 1'b0;
        src_t_data  = '0;
        src_t_keep  = 8'hFF;
        src_t_strb  = 8'hFF;
        src_t_last  = 1'b0;
        src_t_user  = '0;
        src_t_dest  = '0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check_eq("rst_outputs", {dst_t_valid, dst_t_data, dst_t_keep, dst_t_strb, dst_t_last, dst_t_user, dst_t_dest}, '0);
        check_eq("rst_src_ready", src_t_ready, 1'b1);
        @(posedge aclk);
        #1;
        areset = 1'b0;

        // Smoke: two beats collapse into one full output beat
        send(64'h00_10_20_30_00_11_21_31, 1'b0, 1'b0, 1'b0);
        check_eq("smoke_no_early", dst_t_valid, 1'b0);
        send(64'h00_40_50_60_00_41_51_61, 1'b1, 1'b0, 1'b0);
        check_eq("smoke_latency", dst_t_valid, 1'b1);
        check_eq("smoke_data", dst_t_data, 64'h61405141_31102111);
        check_eq("smoke_keep_last", {dst_t_keep, dst_t_last}, {8'hFF, 1'b1});
        drain();

        // Rounding and decimation on a single-beat frame
        send(64'h00_AA_02_13_00_CC_01_10, 1'b1, 1'b0, 1'b0);
        check_eq("round_u", dst_t_data[15:8], 8'h02);
        check_eq("round_v", dst_t_data[31:24], 8'h12);
        check_eq("dec_u", dec_data[15:8], 8'h01);
        send(64'h00_00_FF_FF_00_00_FF_FF, 1'b1, 1'b0, 1'b0);
        check_eq("round_ff", dst_t_data[15:8], 8'hFF);
        check_eq("round_ff_v", dst_t_data[31:24], 8'hFF);
        drain();

        // Odd-length frame, then a fresh even frame
        send({$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
        send({$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
        check_eq("odd_first", {dst_t_keep, dst_t_last}, {8'hFF, 1'b0});
        send({$urandom, $urandom}, 1'b1, 1'b0, 1'b0);
        check_eq("odd_half", {dst_t_keep, dst_t_last, dst_t_data[63:32]}, {8'h0F, 1'b1, 32'h0});
        send({$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
        send({$urandom, $urandom}, 1'b1, 1'b0, 1'b0);
        check_eq("after_odd_full", dst_t_keep, 8'hFF);
        drain();

        // Sideband follows the first beat of each pair
        send({$urandom, $urandom}, 1'b0, 1'b1, 1'(C_CHAIN));
        send({$urandom, $urandom}, 1'b1, 1'b0, 1'b0);
        check_eq("side_match", {dst_t_user, dst_t_dest}, 2'b10);
        send({$urandom, $urandom}, 1'b0, 1'b1, 1'b0);
        send({$urandom, $urandom}, 1'b1, 1'b0, 1'(C_CHAIN));
        check_eq("side_nomatch", {dst_t_user, dst_t_dest}, 2'b00);
        drain();

        // Backpressure: one pending output blocks the source
        set_ready(2);
        send({$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
        send({$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
        q           = {$urandom, $urandom};
        src_t_data  = q;
        src_t_last  = 1'b1;
        src_t_valid = 1'b1;
        repeat (10) begin
            @(negedge aclk);
            check_eq("bp_src_ready", src_t_ready, 1'b0);
        end
        @(posedge aclk);
        #1;
        set_ready(0);
        send(q, 1'b1, 1'b0, 1'b0);
        drain();

        // Random stream with random valid gaps and random ready
        set_ready(1);
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge aclk);
                #1;
            end
            send({$urandom, $urandom}, (i == 999) || ($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drain();

        // Reset drops a stalled output beat
        set_ready(2);
        send({$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
        send({$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
        check_eq("rst_pre_valid", dst_t_valid, 1'b1);
        areset = 1'b1;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        check_eq("rst_mid_valid", {dst_t_valid, dst_t_keep}, 9'h0);

        // Reset discards a half-filled pair
        set_ready(0);
        send({$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
        areset = 1'b1;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        q = {$urandom, $urandom};
        send(q, 1'b1, 1'b0, 1'b0);
        check_eq("rst_new_pair", dst_t_data, {32'h0, model_word(q, 1'b1)});
        check_eq("rst_new_keep", dst_t_keep, 8'h0F);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
